// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional occupancy statistics are enabled with `define MEM_WB_STAGE_STATS_EN.
module mem_wb_skid_stage #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_M,
  input  logic [DATA_W-1:0] mem_data_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic [REG_W-1:0]  write_reg_M,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_W,
  output logic [DATA_W-1:0] mem_data_W,
  output logic [DATA_W-1:0] alu_out_W,
  output logic [REG_W-1:0]  write_reg_W,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic accept;
  logic consume;
  logic loadMain;
  logic loadSkid;
  logic mainFromSkid;

  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainMem;
  logic [DATA_W-1:0] mainAlu;
  logic [REG_W-1:0]  mainReg;

  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidMem;
  logic [DATA_W-1:0] skidAlu;
  logic [REG_W-1:0]  skidReg;

  // Handshake flags come straight from the state register, so in_ready
  // never combinationally depends on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    accept       = in_valid & in_ready;
    consume      = out_valid & out_ready;

    case (state)
      EMPTY: begin
        if (accept) begin
          loadMain  = 1'b1;
          stateNext = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          loadMain = 1'b1;
        end else if (accept) begin
          loadSkid  = 1'b1;
          stateNext = FULL;
        end else if (consume) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          mainFromSkid = 1'b1;
          stateNext    = ONE;
        end
      end
      default: begin
        stateNext = EMPTY;
      end
    endcase

    // Flush overrides every transfer; data regs keep stale contents.
    if (flush) begin
      stateNext    = EMPTY;
      loadMain     = 1'b0;
      loadSkid     = 1'b0;
      mainFromSkid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainCtrl <= '0;
      mainMem  <= '0;
      mainAlu  <= '0;
      mainReg  <= '0;
    end else if (loadMain) begin
      mainCtrl <= ctrl_M;
      mainMem  <= mem_data_M;
      mainAlu  <= alu_out_M;
      mainReg  <= write_reg_M;
    end else if (mainFromSkid) begin
      mainCtrl <= skidCtrl;
      mainMem  <= skidMem;
      mainAlu  <= skidAlu;
      mainReg  <= skidReg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skidCtrl <= '0;
      skidMem  <= '0;
      skidAlu  <= '0;
      skidReg  <= '0;
    end else if (loadSkid) begin
      skidCtrl <= ctrl_M;
      skidMem  <= mem_data_M;
      skidAlu  <= alu_out_M;
      skidReg  <= write_reg_M;
    end
  end

  assign ctrl_W      = out_valid ? mainCtrl : '0;
  assign mem_data_W  = mainMem;
  assign alu_out_W   = mainAlu;
  assign write_reg_W = mainReg;

`ifdef MEM_WB_STAGE_STATS_EN
  logic [31:0] stallCntQ;
  logic [31:0] bubbleCntQ;

  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCntQ  <= '0;
      bubbleCntQ <= '0;
    end else begin
      if (out_valid && !out_ready && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if (!out_valid && (bubbleCntQ != '1)) begin
        bubbleCntQ <= bubbleCntQ + 32'd1;
      end
    end
  end

  assign stall_cnt  = stallCntQ;
  assign bubble_cnt = bubbleCntQ;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule
